// File: rtl/vtx_rasterizer_pkg.sv
// raster_pkg: shared definitions for the vtx_rasterizer wireframe line engine.
// - Default screen geometry and fixed-point format.
// - FSM state encoding.
// - Internal coordinate and error-term widths.
// There are no ports; the package is imported by every rasterizer file.
package raster_pkg;

  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_FRAC_BITS = 8;

  // A mapped coordinate may land well off screen, so it is kept as 17-bit
  // signed. The Bresenham error term needs two extra bits beyond that.
  localparam int SCR_W   = 17;
  localparam int ERR_W   = SCR_W + 2;
  localparam int PIX_X_W = 10;
  localparam int PIX_Y_W = 9;
  localparam int VTX_W   = 16;

  typedef logic signed [SCR_W-1:0] scr_t;
  typedef logic signed [ERR_W-1:0] err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SETUP = 2'd2,
    ST_DRAW  = 2'd3
  } state_e;

endpackage

// File: rtl/vtx_rasterizer_if.sv
// vtx_rasterizer_if: bundles the vertex input stream and the pixel output
// stream of the rasterizer.
//   slave  modport : rasterizer side (consumes vertices, produces pixels)
//   master modport : environment side (produces vertices, consumes pixels)
// Signals:
//   iVtxValid/oVtxReady          vertex handshake
//   iVtxX/iVtxY                  signed fixed-point projected coordinates
//   iNewObj/iException           polyline start / invalid-vertex flags
//   oPixValid/iPixReady          pixel handshake
//   oPixX/oPixY                  screen column / row
//   oBusy                        a line is being set up or drawn
interface vtx_rasterizer_if;
  import raster_pkg::*;

  logic               iVtxValid;
  logic               oVtxReady;
  logic [VTX_W-1:0]   iVtxX;
  logic [VTX_W-1:0]   iVtxY;
  logic               iNewObj;
  logic               iException;
  logic               oPixValid;
  logic               iPixReady;
  logic [PIX_X_W-1:0] oPixX;
  logic [PIX_Y_W-1:0] oPixY;
  logic               oBusy;

  modport slave (
    input  iVtxValid, iVtxX, iVtxY, iNewObj, iException, iPixReady,
    output oVtxReady, oPixValid, oPixX, oPixY, oBusy
  );

  modport master (
    output iVtxValid, iVtxX, iVtxY, iNewObj, iException, iPixReady,
    input  oVtxReady, oPixValid, oPixX, oPixY, oBusy
  );

endinterface

// File: rtl/vtx_rasterizer_stepper.sv
// line_stepper: Bresenham core for one segment.
// Ports:
//   clk            clock
//   load           latch the segment (x0,y0)->(x1,y1) and compute its setup terms
//   step           advance the current point one Bresenham step
//   x0,y0,x1,y1    segment endpoints in screen coordinates
//   cx_nxt,cy_nxt  the current point as it will be after this edge
//   at_end         the current point equals the endpoint
// The block holds only datapath registers, so it has no reset: the parent
// never acts on them until after a load.
module line_stepper
  import raster_pkg::*;
(
  input  logic clk,
  input  logic load,
  input  logic step,
  input  scr_t x0,
  input  scr_t y0,
  input  scr_t x1,
  input  scr_t y1,
  output scr_t cx_nxt,
  output scr_t cy_nxt,
  output logic at_end
);

  scr_t cx_q, cx_d, cy_q, cy_d, x1_q, x1_d, y1_q, y1_d;
  err_t dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  err_t                   ddx, ddy, adx, ady;
  logic signed [ERR_W:0]  e2, dx_ext, dy_ext;
  logic                   take_x, take_y;

  always_comb begin
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    ddx = {{2{x1[SCR_W-1]}}, x1} - {{2{x0[SCR_W-1]}}, x0};
    ddy = {{2{y1[SCR_W-1]}}, y1} - {{2{y0[SCR_W-1]}}, y0};
    adx = ddx[ERR_W-1] ? -ddx : ddx;
    ady = ddy[ERR_W-1] ? -ddy : ddy;

    // Both step decisions compare against 2*err taken from the same old err.
    e2     = {err_q, 1'b0};
    dx_ext = {dx_q[ERR_W-1], dx_q};
    dy_ext = {dy_q[ERR_W-1], dy_q};
    take_x = (e2 >= dy_ext);
    take_y = (e2 <= dx_ext);

    if (load) begin
      dx_d     = adx;
      dy_d     = -ady;
      err_d    = adx - ady;
      sx_neg_d = ddx[ERR_W-1];
      sy_neg_d = ddy[ERR_W-1];
      cx_d     = x0;
      cy_d     = y0;
      x1_d     = x1;
      y1_d     = y1;
    end else if (step) begin
      err_d = err_q + (take_x ? dy_q : '0) + (take_y ? dx_q : '0);
      if (take_x) cx_d = sx_neg_q ? cx_q - 17'sd1 : cx_q + 17'sd1;
      if (take_y) cy_d = sy_neg_q ? cy_q - 17'sd1 : cy_q + 17'sd1;
    end
  end

  always_ff @(posedge clk) begin
    dx_q     <= dx_d;
    dy_q     <= dy_d;
    err_q    <= err_d;
    cx_q     <= cx_d;
    cy_q     <= cy_d;
    x1_q     <= x1_d;
    y1_q     <= y1_d;
    sx_neg_q <= sx_neg_d;
    sy_neg_q <= sy_neg_d;
  end

  assign cx_nxt = cx_d;
  assign cy_nxt = cy_d;
  assign at_end = (cx_q == x1_q) && (cy_q == y1_q);

endmodule

// File: rtl/vtx_rasterizer.sv
// vtx_rasterizer: wireframe line rasterizer. Maps projected fixed-point
// vertices to screen coordinates and emits a Bresenham line of pixel-write
// requests from the previous vertex of an object to the current one.
// Ports:
//   iClock   clock
//   iReset   synchronous active-high reset
//   bus      vtx_rasterizer_if.slave (vertex in, pixel out, busy)
// The parent owns the vertex handshake, coordinate mapping, clipping and the
// registered pixel outputs. The line_stepper instance walks the segment.
module vtx_rasterizer
  import raster_pkg::*;
#(
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES
) (
  input  logic              iClock,
  input  logic              iReset,
  vtx_rasterizer_if.slave   bus
);

  function automatic scr_t map_x(input logic [VTX_W-1:0] v);
    scr_t ext;
    ext = {v[VTX_W-1], v};
    return (ext >>> FRAC_BITS) + scr_t'(H_RES / 2);
  endfunction

  function automatic scr_t map_y(input logic [VTX_W-1:0] v);
    scr_t ext;
    ext = {v[VTX_W-1], v};
    return scr_t'(V_RES / 2) - (ext >>> FRAC_BITS);
  endfunction

  function automatic logic on_screen(input scr_t x, input scr_t y);
    return !x[SCR_W-1] && (x < scr_t'(H_RES)) &&
           !y[SCR_W-1] && (y < scr_t'(V_RES));
  endfunction

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               pix_valid_q, pix_valid_d;
  logic [PIX_X_W-1:0] pix_x_q, pix_x_d;
  logic [PIX_Y_W-1:0] pix_y_q, pix_y_d;
  scr_t               prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  scr_t               end_x_q, end_x_d, end_y_q, end_y_d;

  scr_t vx, vy, cx_nxt, cy_nxt;
  logic accept, advance, load, step, at_end;

  line_stepper u_stepper (
    .clk    (iClock),
    .load   (load),
    .step   (step),
    .x0     (prev_x_q),
    .y0     (prev_y_q),
    .x1     (end_x_q),
    .y1     (end_y_q),
    .cx_nxt (cx_nxt),
    .cy_nxt (cy_nxt),
    .at_end (at_end)
  );

  always_comb begin
    vx       = map_x(bus.iVtxX);
    vy       = map_y(bus.iVtxY);
    accept   = bus.iVtxValid && ready_q;
    // A candidate is finished either by its handshake or, when off screen,
    // immediately because no request was raised for it.
    advance  = (state_q == ST_DRAW) && (!pix_valid_q || bus.iPixReady);
    load     = (state_q == ST_SETUP);
    step     = advance && !at_end;

    state_d  = state_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && !bus.iException) begin
          prev_x_d = vx;
          prev_y_d = vy;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (accept) begin
          if (bus.iException) begin
            state_d = ST_IDLE;
          end else if (bus.iNewObj) begin
            prev_x_d = vx;
            prev_y_d = vy;
          end else begin
            end_x_d = vx;
            end_y_d = vy;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_DRAW;
      ST_DRAW: begin
        if (advance && at_end) begin
          prev_x_d = end_x_q;
          prev_y_d = end_y_q;
          state_d  = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state and the stepper's next
    // point, so they line up with the state they describe.
    ready_d     = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    busy_d      = !ready_d;
    pix_valid_d = (state_d == ST_DRAW) && on_screen(cx_nxt, cy_nxt);
    pix_x_d     = pix_valid_d ? cx_nxt[PIX_X_W-1:0] : '0;
    pix_y_d     = pix_valid_d ? cy_nxt[PIX_Y_W-1:0] : '0;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
    end
  end

  // Vertex storage is only meaningful once the FSM has moved past IDLE.
  always_ff @(posedge iClock) begin
    prev_x_q <= prev_x_d;
    prev_y_q <= prev_y_d;
    end_x_q  <= end_x_d;
    end_y_q  <= end_y_d;
  end

  assign bus.oVtxReady = ready_q;
  assign bus.oBusy     = busy_q;
  assign bus.oPixValid = pix_valid_q;
  assign bus.oPixX     = pix_x_q;
  assign bus.oPixY     = pix_y_q;

endmodule

// File: tb/tb_vtx_rasterizer.sv
// Directed bench for vtx_rasterizer. A second instance with FRAC_BITS=6 is
// used for the clipping case, since Q8.8 input cannot reach off screen at
// the default 640x480 geometry.
module tb_vtx_rasterizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vtx_rasterizer_if vif();
  vtx_rasterizer_if cif();

  vtx_rasterizer u_dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (vif.slave)
  );

  vtx_rasterizer #(.FRAC_BITS(6)) u_clip (
    .iClock (clk),
    .iReset (rst),
    .bus    (cif.slave)
  );

  int checks   = 0;
  int failures = 0;
  int px[$];
  int py[$];
  int stall_idx = -1;
  int stall_len = 0;
  int hold_x    = -1;
  int hold_cnt  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic nobj, input logic exc);
    int n;
    n = 0;
    while (vif.oVtxReady !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("vtx_ready", int'(vif.oVtxReady), 1);
    vif.iVtxX      = x;
    vif.iVtxY      = y;
    vif.iNewObj    = nobj;
    vif.iException = exc;
    vif.iVtxValid  = 1'b1;
    tick;
    vif.iVtxValid  = 1'b0;
    vif.iNewObj    = 1'b0;
    vif.iException = 1'b0;
  endtask

  // Gathers handshaken pixels until the line finishes; returns the cycle
  // offset (from the vertex-accept sample point) of the first pixel.
  task automatic collect(input int budget, output int first);
    int c, idx, stall_left;
    c = 0;
    idx = 0;
    stall_left = stall_len;
    first = -1;
    hold_cnt = 0;
    px.delete();
    py.delete();
    while (c < budget) begin
      if (vif.oPixValid) begin
        if (int'(vif.oPixX) == hold_x) hold_cnt++;
        if (idx == stall_idx && stall_left > 0) begin
          vif.iPixReady = 1'b0;
          stall_left--;
        end else begin
          vif.iPixReady = 1'b1;
          if (first < 0) first = c;
          px.push_back(int'(vif.oPixX));
          py.push_back(int'(vif.oPixY));
          idx++;
        end
      end else begin
        vif.iPixReady = 1'b1;
      end
      if (!vif.oBusy && !vif.oPixValid) break;
      tick;
      c++;
    end
    vif.iPixReady = 1'b1;
    chk("line_done_in_budget", int'(c < budget), 1);
  endtask

  task automatic chk_hline(input string tag, input int n, input int x0, input int y0);
    chk({tag, "_count"}, px.size(), n);
    for (int i = 0; i < n && i < px.size(); i++) begin
      chk({tag, "_x"}, px[i], x0 + i);
      chk({tag, "_y"}, py[i], y0);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int v;
    v = 0;
    repeat (n) begin
      if (vif.oPixValid || vif.oBusy) v++;
      tick;
    end
    chk(tag, v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int cyc;
    int busy_cyc;
    int sx[4];
    int sy[4];

    vif.iVtxValid = 1'b0; vif.iVtxX = '0; vif.iVtxY = '0;
    vif.iNewObj = 1'b0; vif.iException = 1'b0; vif.iPixReady = 1'b1;
    cif.iVtxValid = 1'b0; cif.iVtxX = '0; cif.iVtxY = '0;
    cif.iNewObj = 1'b0; cif.iException = 1'b0; cif.iPixReady = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) tick;
    chk("rst_ready", int'(vif.oVtxReady), 0);
    chk("rst_valid", int'(vif.oPixValid), 0);
    chk("rst_x", int'(vif.oPixX), 0);
    chk("rst_y", int'(vif.oPixY), 0);
    chk("rst_busy", int'(vif.oBusy), 0);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", int'(vif.oVtxReady), 1);

    // Horizontal line (0,0)->(4,0): (320..324,240)
    send(16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h0400, 16'h0000, 1'b0, 1'b0);
    chk("hz_setup_busy", int'(vif.oBusy), 1);
    chk("hz_setup_noready", int'(vif.oVtxReady), 0);
    collect(40, first);
    chk("hz_first_latency", first, 1);
    chk_hline("hz", 5, 320, 240);
    chk("hz_ready_back", int'(vif.oVtxReady), 1);

    // Steep diagonal (0,0)->(1,3)
    send(16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h0100, 16'h0300, 1'b0, 1'b0);
    collect(40, first);
    sx = '{320, 320, 321, 321};
    sy = '{240, 239, 238, 237};
    chk("steep_count", px.size(), 4);
    for (int i = 0; i < 4 && i < px.size(); i++) begin
      chk("steep_x", px[i], sx[i]);
      chk("steep_y", py[i], sy[i]);
    end

    // Backpressure: third pixel stalled for 3 cycles
    stall_idx = 2; stall_len = 3; hold_x = 322;
    send(16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h0400, 16'h0000, 1'b0, 1'b0);
    collect(40, first);
    chk("bp_hold_cycles", hold_cnt, 4);
    chk_hline("bp", 5, 320, 240);
    stall_idx = -1; stall_len = 0; hold_x = -1;

    // Clipping on the FRAC_BITS=6 instance: x -10..2 on row 240
    chk("clip_ready0", int'(cif.oVtxReady), 1);
    cif.iVtxX = 16'hAD80; cif.iVtxY = 16'h0000; cif.iNewObj = 1'b1; cif.iVtxValid = 1'b1;
    tick;
    chk("clip_ready1", int'(cif.oVtxReady), 1);
    cif.iVtxX = 16'hB080; cif.iNewObj = 1'b0;
    tick;
    cif.iVtxValid = 1'b0;
    px.delete(); py.delete();
    busy_cyc = 0;
    cyc = 0;
    while (cif.oBusy && cyc < 60) begin
      if (cif.oPixValid) begin
        px.push_back(int'(cif.oPixX));
        py.push_back(int'(cif.oPixY));
      end
      busy_cyc++;
      tick;
      cyc++;
    end
    chk("clip_busy_cycles", busy_cyc, 14);
    chk_hline("clip", 3, 0, 240);

    // Object and exception control
    send(16'h0000, 16'h0000, 1'b1, 1'b0);          // A
    send(16'h0200, 16'h0000, 1'b0, 1'b0);          // B
    collect(40, first);
    chk_hline("ab", 3, 320, 240);
    send(16'h0100, 16'h0100, 1'b1, 1'b0);          // C, new object
    quiet("c_no_pixels", 4);
    send(16'h0300, 16'h0000, 1'b0, 1'b1);          // D, exception
    quiet("d_no_pixels", 4);
    send(16'h0000, 16'h0100, 1'b0, 1'b0);          // E, stored from IDLE
    quiet("e_no_pixels", 4);
    send(16'h0200, 16'h0100, 1'b0, 1'b0);          // F
    collect(40, first);
    chk_hline("ef", 3, 320, 239);

    // Reset in the middle of a 20-pixel line
    send(16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h1300, 16'h0000, 1'b0, 1'b0);
    repeat (6) tick;
    chk("mid_valid", int'(vif.oPixValid), 1);
    rst = 1'b1;
    tick;
    chk("mid_rst_ready", int'(vif.oVtxReady), 0);
    chk("mid_rst_valid", int'(vif.oPixValid), 0);
    chk("mid_rst_x", int'(vif.oPixX), 0);
    chk("mid_rst_y", int'(vif.oPixY), 0);
    chk("mid_rst_busy", int'(vif.oBusy), 0);
    rst = 1'b0;
    tick;
    chk("mid_ready_after", int'(vif.oVtxReady), 1);
    send(16'h0000, 16'h0100, 1'b1, 1'b0);
    send(16'h0100, 16'h0100, 1'b0, 1'b0);
    collect(40, first);
    chk_hline("fresh", 2, 320, 239);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
